count_sequencer: RTL and testbench
==================================

Name: count_sequencer

Overview:
- Controller that sequences the rate-divider/display-counter datapath as a programmable timed run.
- On start it latches a frequency select, a start value and a terminal value, then advances a CNT_W-bit count once per divided period until the terminal value is reached.
- Supports pause/resume and abort.
- Sits between the switch/key inputs and the hex decoder; count feeds the 7-segment decoder directly.

Parameters:
- DIV_W, 28, width of internal period down-counter
- CNT_W, 4, width of count
- P0, 0, reload for freq_sel=00 (one tick every P0+1 clocks)
- P1, 49999999, reload for freq_sel=01
- P2, 99999999, reload for freq_sel=10
- P3, 199999999, reload for freq_sel=11

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  level; begins a run from IDLE or DONE
- pause  in  1  level; holds RUN while high
- abort  in  1  level; returns to IDLE, highest priority
- freq_sel  in  2  period select, sampled only on start
- load_val  in  CNT_W  initial count, sampled only on start
- limit  in  CNT_W  terminal count, sampled only on start
- count  out  CNT_W  current count value (registered)
- tick  out  1  one-cycle pulse coincident with each count update
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11
- done  out  1  high while state==DONE

Behaviour:
- Reset (async, reset_n=0): state=IDLE, count=0, tick=0, done=0, divider=0, latched sel/limit=0. Release takes effect at the next rising edge.
- Priority each cycle: abort > pause > start > divider expiry.
- IDLE:
  - start=1: at that edge count<=load_val, lim_q<=limit, div<=P[freq_sel].
  - If load_val==limit, next state is DONE; otherwise RUN.
  - No tick on the start edge.
- RUN, each cycle:
  - If div!=0: div<=div-1.
  - If div==0: div<=P[sel_q], count<=count+1 (modulo 2^CNT_W, 1111->0000 wrap), tick<=1 for exactly that one cycle.
  - If count+1==lim_q: state<=DONE at the same edge.
  - Latency from the start edge to the first tick is P[sel]+1 clocks.
- pause=1 in RUN: state<=PAUSE; div and count frozen; no tick, even if div==0 that cycle.
- PAUSE:
  - Holds while pause=1.
  - pause=0: state<=RUN with div unchanged, so the remaining period resumes exactly.
- DONE:
  - count held; done=1; tick=0.
  - start=1 restarts exactly as from IDLE, sampling new inputs.
- abort=1 in any state: state<=IDLE, count<=0, div<=0, tick<=0.
- start while in RUN or PAUSE is ignored. Changes to freq_sel, load_val or limit mid-run are ignored.
- P0=0: a tick every clock in RUN.
- limit below load_val: count wraps through 2^CNT_W-1 -> 0 before reaching limit.
- tick is registered; never high in two consecutive cycles unless the selected P==0.
- reset_n asserted mid-run: immediate return to reset values regardless of clk.

Test Plan:
- P1=3; reset, then start with freq_sel=01, load_val=2, limit=5 -> ticks every 4 clocks; count 2,3,4,5; state=DONE and done=1 on the edge count becomes 5; exactly 3 ticks.
- freq_sel=00, load_val=14, limit=1 -> count 14,15,0,1 on consecutive clocks; wrap verified; tick high 3 consecutive cycles; DONE at count=1.
- P2=7, run started; pause asserted 2 clocks after start for 10 clocks, then released -> count unchanged during PAUSE; first tick arrives 8 total RUN cycles after start (6 remaining after resume).
- load_val=9, limit=9 -> state goes IDLE->DONE on the start edge; count=9; no tick.
- Mid-RUN, abort and pause asserted together -> IDLE, count=0. Separately, reset_n pulsed low between clock edges -> outputs clear immediately.
- In DONE, start with new load_val=0, limit=2, freq_sel=00 -> count 0,1,2; DONE again. During the run, start pulses and freq_sel changes have no effect.

Source files
------------

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - timed count run controller for the rate-divider/display-counter datapath
// Latches period select, start and terminal values on start and steps count once per divided period.
module count_sequencer #(
  parameter int DIV_W = 28,
  parameter int CNT_W = 4,
  parameter int P0    = 0,
  parameter int P1    = 49999999,
  parameter int P2    = 99999999,
  parameter int P3    = 199999999
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [1:0]       freq_sel,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic [1:0]       state,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  logic [DIV_W-1:0] div;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] lim_q;
  logic [CNT_W-1:0] count_inc;

  function automatic logic [DIV_W-1:0] reload(input logic [1:0] s);
    case (s)
      2'b00:   reload = DIV_W'(P0);
      2'b01:   reload = DIV_W'(P1);
      2'b10:   reload = DIV_W'(P2);
      default: reload = DIV_W'(P3);
    endcase
  endfunction

  assign count_inc = count + CNT_W'(1);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      count <= '0;
      tick  <= 1'b0;
      div   <= '0;
      sel_q <= '0;
      lim_q <= '0;
    end else begin
      tick <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        count <= '0;
        div   <= '0;
      end else begin
        case (state)
          // pause outranks start, so a held pause also blocks a (re)start
          S_IDLE, S_DONE: begin
            if (!pause && start) begin
              count <= load_val;
              lim_q <= limit;
              sel_q <= freq_sel;
              div   <= reload(freq_sel);
              state <= (load_val == limit) ? S_DONE : S_RUN;
            end
          end
          S_RUN: begin
            if (pause) begin
              state <= S_PAUSE;
            end else if (div != '0) begin
              div <= div - DIV_W'(1);
            end else begin
              div   <= reload(sel_q);
              count <= count_inc;
              tick  <= 1'b1;
              if (count_inc == lim_q) state <= S_DONE;
            end
          end
          // resume leaves div untouched so the interrupted period completes exactly
          S_PAUSE: begin
            if (!pause) state <= S_RUN;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer
// Tick schedule is derived arithmetically from active (non-paused) clock edges.
module tb_count_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       pause;
  logic       abort;
  logic [1:0] freq_sel;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic [3:0] count;
  logic       tick;
  logic [1:0] state;
  logic       done;

  count_sequencer #(
    .DIV_W(28), .CNT_W(4), .P0(0), .P1(3), .P2(7), .P3(12)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .abort(abort),
    .freq_sel(freq_sel), .load_val(load_val), .limit(limit),
    .count(count), .tick(tick), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int val;
  } exp_t;
  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  function automatic int period(input int sel);
    case (sel)
      0:       return 0;
      1:       return 3;
      2:       return 7;
      default: return 12;
    endcase
  endfunction

  // Monitor: compares every observed or expected tick against the scoreboard.
  initial begin
    exp_t e;
    bit   exp_tick;
    forever begin
      @(posedge clk);
      #1;
      exp_tick = (sb.size() > 0) && (sb[0].at == cyc);
      if (tick || exp_tick) check("tick_present", int'(tick), int'(exp_tick));
      if (exp_tick) begin
        e = sb.pop_front();
        if (tick) check("tick_count", int'(count), e.val);
      end
    end
  end

  task automatic do_run(input int sel, input int ld, input int lm,
                        input int p_at, input int p_len, input bit noise);
    int per, n, e0, last, act, k, frz_lo, frz_hi;
    exp_t x;
    per = period(sel) + 1;
    n   = (lm - ld) & 15;
    if (n == 0) p_len = 0;
    @(negedge clk);
    start = 1'b1; freq_sel = 2'(sel); load_val = 4'(ld); limit = 4'(lm);
    e0 = cyc + 1;
    // edges with pause sampled high, plus the resume edge, do not advance the period
    frz_lo = e0 + p_at;
    frz_hi = e0 + p_at + p_len;
    act = 0; k = 0; last = e0;
    for (int e = e0 + 1; k < n; e++) begin
      if (!(p_len > 0 && e >= frz_lo && e <= frz_hi)) begin
        act++;
        if (act % per == 0) begin
          k++;
          x.at  = e;
          x.val = (ld + k) & 15;
          sb.push_back(x);
          last = e;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("start_state", int'(state), (n == 0) ? 3 : 1);
    check("start_count", int'(count), ld);
    check("start_done", int'(done), (n == 0) ? 1 : 0);
    while (cyc < last) begin
      if (p_len > 0 && cyc >= frz_lo && cyc < frz_lo + p_len)
        check("pause_state", int'(state), 2);
      pause = (p_len > 0 && cyc + 1 >= frz_lo && cyc + 1 < frz_lo + p_len);
      if (noise) begin
        start    = (cyc + 1 < last) && ($urandom_range(0, 3) == 0);
        freq_sel = 2'($urandom);
        load_val = 4'($urandom);
        limit    = 4'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    pause = 1'b0;
    check("end_state", int'(state), 3);
    check("end_done", int'(done), 1);
    check("end_count", int'(count), lm);
    @(negedge clk);
    check("hold_state", int'(state), 3);
    check("hold_count", int'(count), lm);
  endtask

  initial begin
    int sel, ld, lm, pl, pa;
    exp_t x;
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    freq_sel = 2'b00; load_val = 4'd0; limit = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_state", int'(state), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_done", int'(done), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_state", int'(state), 0);

    do_run(1, 2, 5, 0, 0, 1'b0);
    do_run(0, 14, 1, 0, 0, 1'b0);
    do_run(2, 0, 1, 2, 10, 1'b0);
    do_run(3, 9, 9, 0, 0, 1'b0);
    do_run(0, 0, 2, 0, 0, 1'b1);

    // abort together with pause mid-run, before the first period expires
    @(negedge clk);
    start = 1'b1; freq_sel = 2'd2; load_val = 4'd3; limit = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_count", int'(count), 3);
    abort = 1'b1; pause = 1'b1;
    @(negedge clk);
    abort = 1'b0; pause = 1'b0;
    check("abort_state", int'(state), 0);
    check("abort_count", int'(count), 0);
    check("abort_done", int'(done), 0);

    for (int r = 0; r < 25; r++) begin
      sel = $urandom_range(0, 3);
      ld  = $urandom_range(0, 15);
      lm  = $urandom_range(0, 15);
      pl  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      pa  = $urandom_range(1, period(sel) + 1);
      do_run(sel, ld, lm, pa, pl, 1'($urandom_range(0, 1)));
    end

    // asynchronous reset between edges while ticking every clock
    @(negedge clk);
    start = 1'b1; freq_sel = 2'd0; load_val = 4'd5; limit = 4'd12;
    for (int k = 1; k <= 3; k++) begin
      x.at  = cyc + 1 + k;
      x.val = 5 + k;
      sb.push_back(x);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_count", int'(count), 8);
    check("pre_reset_tick", int'(tick), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_state", int'(state), 0);
    check("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
